// File: rtl/mem_write_checker.sv
// mem_write_checker
// Monitors the data-memory write port of the single-cycle core. Each committed
// store is compared, in order, against a programmable table of expected
// (address, data) pairs. Stores to SCRATCH_ADDR are tolerated. The block
// reports pass, fail (wrong address / wrong data) or timeout.
//
// Optional build macro: MWC_FAIL_CAPTURE_EN adds fail_addr/fail_data, which
// hold the failing store's address and data.
//
// Ports
//   clk, reset         rising-edge clock, synchronous active-high reset
//   cfg_we/idx/addr/data  table write port (IDLE only)
//   cfg_count          expected writes per run, sampled on start
//   start              begin a run (from IDLE, PASS or FAIL)
//   MemWrite/DataAdr/WriteData  store port of the core
//   busy/pass/fail     RUN / PASS / FAIL indicators
//   fail_code          0 none, 1 wrong address, 2 wrong data, 3 timeout
//   match_ptr          expected writes matched so far
//   cycle_cnt          cycles spent in the current or last run
//
// state | meaning
// IDLE  | after reset; table writable, waiting for start
// RUN   | checking stores, counting cycles
// PASS  | all expected writes seen; sticky until start
// FAIL  | mismatch or timeout; sticky until start
module mem_write_checker #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int DEPTH = 8,
   parameter int TIMEOUT = 1000,
   parameter logic [ADDR_W-1:0] SCRATCH_ADDR = 96
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         cfg_we,
   input  logic [$clog2(DEPTH)-1:0]     cfg_idx,
   input  logic [ADDR_W-1:0]            cfg_addr,
   input  logic [DATA_W-1:0]            cfg_data,
   input  logic [$clog2(DEPTH):0]       cfg_count,
   input  logic                         start,
   input  logic                         MemWrite,
   input  logic [ADDR_W-1:0]            DataAdr,
   input  logic [DATA_W-1:0]            WriteData,
   output logic                         busy,
   output logic                         pass,
   output logic                         fail,
   output logic [1:0]                   fail_code,
`ifdef MWC_FAIL_CAPTURE_EN
   output logic [ADDR_W-1:0]            fail_addr,
   output logic [DATA_W-1:0]            fail_data,
`endif
   output logic [$clog2(DEPTH):0]       match_ptr,
   output logic [$clog2(TIMEOUT+1)-1:0] cycle_cnt
);

   localparam int IDX_W = $clog2(DEPTH);
   localparam int CNT_W = IDX_W + 1;
   localparam int CYC_W = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_PASS, S_FAIL} state_t;

   state_t state, stateNxt;

   logic [ADDR_W-1:0] tblAddr [DEPTH];
   logic [DATA_W-1:0] tblData [DEPTH];

   logic [CNT_W-1:0] matchPtr, matchPtrNxt, matchPtrInc;
   logic [CNT_W-1:0] runCount, runCountNxt, clampedCount;
   logic [CYC_W-1:0] cycleCnt, cycleCntNxt;
   logic [1:0]       failCode, failCodeNxt;
   logic             addrHit, dataHit, scratchHit, timeoutHit;

`ifdef MWC_FAIL_CAPTURE_EN
   logic [ADDR_W-1:0] failAddrQ, failAddrNxt;
   logic [DATA_W-1:0] failDataQ, failDataNxt;
`endif

   // matchPtr is always below runCount while in RUN, so the low bits index
   // a valid entry whenever the comparison matters.
   assign addrHit     = (DataAdr == tblAddr[matchPtr[IDX_W-1:0]]);
   assign dataHit     = (WriteData == tblData[matchPtr[IDX_W-1:0]]);
   assign scratchHit  = (DataAdr == SCRATCH_ADDR);
   assign timeoutHit  = (cycleCnt == CYC_W'(TIMEOUT - 1));
   assign matchPtrInc = matchPtr + CNT_W'(1);

   always_comb begin
      if (cfg_count == '0)
         clampedCount = CNT_W'(1);
      else if (cfg_count > CNT_W'(DEPTH))
         clampedCount = CNT_W'(DEPTH);
      else
         clampedCount = cfg_count;
   end

   // Table has no reset: contents survive reset so a bench can reload only
   // the entries it changes.
   always_ff @(posedge clk) begin
      if (!reset && state == S_IDLE && cfg_we) begin
         tblAddr[cfg_idx] <= cfg_addr;
         tblData[cfg_idx] <= cfg_data;
      end
   end

   always_comb begin
      stateNxt    = state;
      matchPtrNxt = matchPtr;
      cycleCntNxt = cycleCnt;
      failCodeNxt = failCode;
      runCountNxt = runCount;
`ifdef MWC_FAIL_CAPTURE_EN
      failAddrNxt = failAddrQ;
      failDataNxt = failDataQ;
`endif
      case (state)
         S_RUN: begin
            cycleCntNxt = cycleCnt + CYC_W'(1);
            // Expected match outranks scratch; any store decision outranks timeout.
            if (MemWrite && addrHit) begin
               if (dataHit) begin
                  matchPtrNxt = matchPtrInc;
                  if (matchPtrInc == runCount)
                     stateNxt = S_PASS;
               end else begin
                  stateNxt    = S_FAIL;
                  failCodeNxt = 2'd2;
`ifdef MWC_FAIL_CAPTURE_EN
                  failAddrNxt = DataAdr;
                  failDataNxt = WriteData;
`endif
               end
            end else if (MemWrite && !scratchHit) begin
               stateNxt    = S_FAIL;
               failCodeNxt = 2'd1;
`ifdef MWC_FAIL_CAPTURE_EN
               failAddrNxt = DataAdr;
               failDataNxt = WriteData;
`endif
            end else if (timeoutHit) begin
               stateNxt    = S_FAIL;
               failCodeNxt = 2'd3;
            end
         end
         default: begin
            if (start) begin
               stateNxt    = S_RUN;
               matchPtrNxt = '0;
               cycleCntNxt = '0;
               failCodeNxt = 2'd0;
               runCountNxt = clampedCount;
`ifdef MWC_FAIL_CAPTURE_EN
               failAddrNxt = '0;
               failDataNxt = '0;
`endif
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= S_IDLE;
         matchPtr <= '0;
         cycleCnt <= '0;
         failCode <= 2'd0;
         runCount <= '0;
`ifdef MWC_FAIL_CAPTURE_EN
         failAddrQ <= '0;
         failDataQ <= '0;
`endif
      end else begin
         state    <= stateNxt;
         matchPtr <= matchPtrNxt;
         cycleCnt <= cycleCntNxt;
         failCode <= failCodeNxt;
         runCount <= runCountNxt;
`ifdef MWC_FAIL_CAPTURE_EN
         failAddrQ <= failAddrNxt;
         failDataQ <= failDataNxt;
`endif
      end
   end

   assign busy      = (state == S_RUN);
   assign pass      = (state == S_PASS);
   assign fail      = (state == S_FAIL);
   assign fail_code = failCode;
   assign match_ptr = matchPtr;
   assign cycle_cnt = cycleCnt;
`ifdef MWC_FAIL_CAPTURE_EN
   assign fail_addr = failAddrQ;
   assign fail_data = failDataQ;
`endif

endmodule

// File: tb/tb_mem_write_checker.sv
module tb_mem_write_checker;
   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;
   localparam int DEPTH = 8;
   localparam int TIMEOUT = 20;
   localparam logic [31:0] SCRATCH = 32'd96;
   localparam int IDX_W = 3;
   localparam int CNT_W = 4;
   localparam int CYC_W = 5;

   logic clk = 1'b0;
   logic reset, cfg_we, start, MemWrite;
   logic [IDX_W-1:0] cfg_idx;
   logic [ADDR_W-1:0] cfg_addr, DataAdr;
   logic [DATA_W-1:0] cfg_data, WriteData;
   logic [CNT_W-1:0] cfg_count;
   logic busy, pass, fail;
   logic [1:0] fail_code;
   logic [CNT_W-1:0] match_ptr;
   logic [CYC_W-1:0] cycle_cnt;
`ifdef MWC_FAIL_CAPTURE_EN
   logic [ADDR_W-1:0] fail_addr;
   logic [DATA_W-1:0] fail_data;
`endif

   int errors = 0;
   int checks = 0;
   int busyCycles;

   // expected table and store stream seen by the reference model
   logic [31:0] tA [DEPTH];
   logic [31:0] tD [DEPTH];
   bit          qWe [$];
   logic [31:0] qAddr [$];
   logic [31:0] qData [$];

   // reference model results
   logic             mPass, mFail;
   logic [1:0]       mCode;
   logic [CNT_W-1:0] mPtr;
   logic [CYC_W-1:0] mCyc;
   logic [31:0]      mFA, mFD;

   mem_write_checker #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH),
      .TIMEOUT(TIMEOUT), .SCRATCH_ADDR(SCRATCH)
   ) dut (
      .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
      .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_count(cfg_count),
      .start(start), .MemWrite(MemWrite), .DataAdr(DataAdr),
      .WriteData(WriteData), .busy(busy), .pass(pass), .fail(fail),
      .fail_code(fail_code),
`ifdef MWC_FAIL_CAPTURE_EN
      .fail_addr(fail_addr), .fail_data(fail_data),
`endif
      .match_ptr(match_ptr), .cycle_cnt(cycle_cnt)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   task automatic load_table(input int n);
      for (int i = 0; i < n; i++) begin
         cfg_we = 1'b1; cfg_idx = IDX_W'(i); cfg_addr = tA[i]; cfg_data = tD[i];
         tick();
      end
      cfg_we = 1'b0;
   endtask

   task automatic clear_q();
      qWe.delete(); qAddr.delete(); qData.delete();
   endtask

   task automatic push(input bit we, input logic [31:0] a, input logic [31:0] d);
      qWe.push_back(we); qAddr.push_back(a); qData.push_back(d);
   endtask

   // Walks the store list one RUN cycle at a time and stops at the first
   // deciding event: all expected stores seen, a bad store, or the timeout.
   task automatic model_run(input int cnt);
      int eff, ptr;
      bit done;
      eff = (cnt == 0) ? 1 : ((cnt > DEPTH) ? DEPTH : cnt);
      ptr = 0; done = 0;
      mPass = 0; mFail = 0; mCode = 0; mFA = 0; mFD = 0; mCyc = CYC_W'(TIMEOUT);
      for (int c = 1; c <= TIMEOUT && !done; c++) begin
         bit we;
         logic [31:0] a, d;
         we = 0; a = 0; d = 0;
         if (c <= qWe.size()) begin we = qWe[c-1]; a = qAddr[c-1]; d = qData[c-1]; end
         if (we && a == tA[ptr]) begin
            if (d == tD[ptr]) begin
               ptr++;
               if (ptr == eff) begin mPass = 1; done = 1; end
            end else begin
               mFail = 1; mCode = 2; mFA = a; mFD = d; done = 1;
            end
         end else if (we && a != SCRATCH) begin
            mFail = 1; mCode = 1; mFA = a; mFD = d; done = 1;
         end else if (c == TIMEOUT) begin
            mFail = 1; mCode = 3; done = 1;
         end
         if (done) mCyc = CYC_W'(c);
      end
      mPtr = CNT_W'(ptr);
   endtask

   // Starts a run and plays the queued stores, one per cycle, well past any
   // verdict; counts how many cycles busy stayed high.
   task automatic run_seq(input int cnt);
      cfg_count = CNT_W'(cnt);
      start = 1'b1;
      tick();
      start = 1'b0;
      busyCycles = 0;
      for (int i = 0; i < TIMEOUT + 4; i++) begin
         if (busy) busyCycles++;
         if (i < qWe.size()) begin
            MemWrite = qWe[i]; DataAdr = qAddr[i]; WriteData = qData[i];
         end else begin
            MemWrite = 1'b0; DataAdr = '0; WriteData = '0;
         end
         tick();
      end
      MemWrite = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if ({busy, pass, fail, fail_code, match_ptr, cycle_cnt} !== '0) begin
         errors++;
         $display("FAIL reset_state: got busy=%0b pass=%0b fail=%0b code=%0d ptr=%0d cyc=%0d, want all 0",
                  busy, pass, fail, fail_code, match_ptr, cycle_cnt);
      end
   endtask

   task automatic test_scratch_pass();
      do_reset();
      tA[0] = 100; tD[0] = 7;
      load_table(1);
      clear_q();
      push(1, 96, 5); push(1, 96, 6); push(1, 100, 7);
      model_run(1);
      run_seq(1);
      checks++;
      if ({pass, fail, fail_code} !== {mPass, mFail, mCode} || mPass !== 1'b1) begin
         errors++;
         $display("FAIL scratch_pass verdict: got pass=%0b fail=%0b code=%0d, want pass=1 fail=0 code=0",
                  pass, fail, fail_code);
      end
      checks++;
      if (match_ptr !== mPtr || busyCycles != 3 || cycle_cnt !== mCyc) begin
         errors++;
         $display("FAIL scratch_pass timing: got ptr=%0d busy_cycles=%0d cyc=%0d, want ptr=%0d busy_cycles=3 cyc=%0d",
                  match_ptr, busyCycles, cycle_cnt, mPtr, mCyc);
      end
   endtask

   task automatic test_wrong_addr();
      clear_q();
      push(1, 104, 7);
      model_run(1);
      run_seq(1);
      checks++;
      if ({busy, pass, fail, fail_code} !== {1'b0, mPass, mFail, mCode} || mCode !== 2'd1) begin
         errors++;
         $display("FAIL wrong_addr: got busy=%0b pass=%0b fail=%0b code=%0d, want busy=0 fail=1 code=1",
                  busy, pass, fail, fail_code);
      end
      checks++;
      if (busyCycles != 1) begin
         errors++;
         $display("FAIL wrong_addr latency: got busy_cycles=%0d, want 1", busyCycles);
      end
`ifdef MWC_FAIL_CAPTURE_EN
      checks++;
      if (fail_addr !== mFA || fail_data !== mFD) begin
         errors++;
         $display("FAIL wrong_addr capture: got %0d/%0d, want %0d/%0d", fail_addr, fail_data, mFA, mFD);
      end
`endif
   endtask

   task automatic test_wrong_data();
      clear_q();
      push(0, 0, 0); push(1, 100, 8);
      model_run(1);
      run_seq(1);
      checks++;
      if ({pass, fail, fail_code} !== {mPass, mFail, mCode} || mCode !== 2'd2) begin
         errors++;
         $display("FAIL wrong_data: got pass=%0b fail=%0b code=%0d, want fail=1 code=2", pass, fail, fail_code);
      end
      checks++;
      if (busyCycles != 2 || cycle_cnt !== 5'd2) begin
         errors++;
         $display("FAIL wrong_data timing: got busy_cycles=%0d cyc=%0d, want 2 and 2", busyCycles, cycle_cnt);
      end
   endtask

   task automatic test_timeout();
      clear_q();
      model_run(1);
      run_seq(1);
      checks++;
      if ({pass, fail, fail_code} !== {mPass, mFail, mCode} || mCode !== 2'd3) begin
         errors++;
         $display("FAIL timeout verdict: got pass=%0b fail=%0b code=%0d, want fail=1 code=3", pass, fail, fail_code);
      end
      checks++;
      if (cycle_cnt !== 5'd20 || busyCycles != TIMEOUT) begin
         errors++;
         $display("FAIL timeout count: got cyc=%0d busy_cycles=%0d, want 20 and 20", cycle_cnt, busyCycles);
      end
`ifdef MWC_FAIL_CAPTURE_EN
      checks++;
      if (fail_addr !== '0 || fail_data !== '0) begin
         errors++;
         $display("FAIL timeout capture: got %0d/%0d, want 0/0", fail_addr, fail_data);
      end
`endif
   endtask

   task automatic test_timeout_edge_store();
      clear_q();
      for (int i = 0; i < TIMEOUT - 1; i++) push(0, 0, 0);
      push(1, 100, 7);
      model_run(1);
      run_seq(1);
      checks++;
      if ({pass, fail, fail_code} !== {mPass, mFail, mCode} || mPass !== 1'b1 || cycle_cnt !== 5'd20) begin
         errors++;
         $display("FAIL timeout_edge: got pass=%0b fail=%0b code=%0d cyc=%0d, want pass=1 code=0 cyc=20",
                  pass, fail, fail_code, cycle_cnt);
      end
   endtask

   task automatic test_multi_and_rerun();
      do_reset();
      tA[0] = 100; tD[0] = 7; tA[1] = 104; tD[1] = 9; tA[2] = 108; tD[2] = 1;
      load_table(3);
      clear_q();
      push(1, 100, 7); push(1, 96, 1); push(1, 104, 9); push(0, 0, 0); push(1, 96, 2); push(1, 108, 1);
      model_run(3);
      run_seq(3);
      checks++;
      if (pass !== mPass || match_ptr !== mPtr || mPtr !== 4'd3 || busyCycles != 6) begin
         errors++;
         $display("FAIL multi_pass: got pass=%0b ptr=%0d busy_cycles=%0d, want pass=1 ptr=3 busy_cycles=6",
                  pass, match_ptr, busyCycles);
      end
      clear_q();
      push(1, 104, 9);
      model_run(3);
      run_seq(3);
      checks++;
      if ({fail, fail_code, match_ptr} !== {mFail, mCode, mPtr} || mCode !== 2'd1) begin
         errors++;
         $display("FAIL out_of_order: got fail=%0b code=%0d ptr=%0d, want fail=1 code=1 ptr=0",
                  fail, fail_code, match_ptr);
      end
   endtask

   task automatic test_reset_midrun();
      cfg_count = 4'd3;
      start = 1'b1; tick(); start = 1'b0;
      MemWrite = 1'b1; DataAdr = 100; WriteData = 7; tick();
      MemWrite = 1'b0; tick();
      checks++;
      if (busy !== 1'b1 || match_ptr !== 4'd1) begin
         errors++;
         $display("FAIL midrun_setup: got busy=%0b ptr=%0d, want busy=1 ptr=1", busy, match_ptr);
      end
      do_reset();
      checks++;
      if ({busy, pass, fail, fail_code, match_ptr, cycle_cnt} !== '0) begin
         errors++;
         $display("FAIL midrun_reset: got busy=%0b pass=%0b fail=%0b code=%0d ptr=%0d cyc=%0d, want all 0",
                  busy, pass, fail, fail_code, match_ptr, cycle_cnt);
      end
      tA[0] = 200; tD[0] = 3;
      load_table(1);
      clear_q();
      push(1, 200, 3);
      model_run(1);
      run_seq(1);
      checks++;
      if (pass !== mPass || mPass !== 1'b1 || match_ptr !== mPtr) begin
         errors++;
         $display("FAIL after_reset_run: got pass=%0b ptr=%0d, want pass=1 ptr=1", pass, match_ptr);
      end
   endtask

   task automatic test_cfg_ignored();
      // DUT sits in PASS: this table write must be dropped
      cfg_we = 1'b1; cfg_idx = 0; cfg_addr = 300; cfg_data = 4;
      tick();
      cfg_we = 1'b0;
      clear_q();
      push(1, 200, 3);
      model_run(1);
      run_seq(1);
      checks++;
      if ({pass, fail, fail_code} !== {mPass, mFail, mCode}) begin
         errors++;
         $display("FAIL cfg_ignored: got pass=%0b fail=%0b code=%0d, want pass=%0b fail=%0b code=%0d",
                  pass, fail, fail_code, mPass, mFail, mCode);
      end
   endtask

   task automatic test_count_zero();
      do_reset();
      tA[0] = 100; tD[0] = 7; tA[1] = 104; tD[1] = 9;
      load_table(2);
      clear_q();
      push(1, 100, 7); push(1, 104, 9);
      model_run(0);
      run_seq(0);
      checks++;
      if (pass !== mPass || match_ptr !== mPtr || mPtr !== 4'd1 || busyCycles != 1) begin
         errors++;
         $display("FAIL count_zero: got pass=%0b ptr=%0d busy_cycles=%0d, want pass=1 ptr=1 busy_cycles=1",
                  pass, match_ptr, busyCycles);
      end
   endtask

   task automatic test_random();
      for (int it = 0; it < 40; it++) begin
         int cnt, gp, r;
         do_reset();
         for (int i = 0; i < DEPTH; i++) begin
            tA[i] = 32'(4 * $urandom_range(20, 40));
            tD[i] = 32'($urandom_range(0, 15));
         end
         load_table(DEPTH);
         cnt = (it == 0) ? 15 : int'($urandom_range(0, 15));
         clear_q();
         gp = 0;
         for (int c = 0; c < TIMEOUT; c++) begin
            r = $urandom_range(0, 99);
            if (r < 55) begin push(1, tA[gp % DEPTH], tD[gp % DEPTH]); gp++; end
            else if (r < 75) push(0, 0, 0);
            else if (r < 88) push(1, SCRATCH, $urandom);
            else if (r < 94) push(1, tA[gp % DEPTH] + 4, tD[gp % DEPTH]);
            else push(1, tA[gp % DEPTH], tD[gp % DEPTH] ^ 32'd1);
         end
         model_run(cnt);
         run_seq(cnt);
         checks++;
         if ({pass, fail, fail_code, match_ptr} !== {mPass, mFail, mCode, mPtr}) begin
            errors++;
            $display("FAIL random[%0d] verdict: got pass=%0b fail=%0b code=%0d ptr=%0d, want %0b %0b %0d %0d",
                     it, pass, fail, fail_code, match_ptr, mPass, mFail, mCode, mPtr);
         end
         checks++;
         if (cycle_cnt !== mCyc || busyCycles != int'(mCyc)) begin
            errors++;
            $display("FAIL random[%0d] timing: got cyc=%0d busy_cycles=%0d, want %0d",
                     it, cycle_cnt, busyCycles, mCyc);
         end
`ifdef MWC_FAIL_CAPTURE_EN
         checks++;
         if (fail_addr !== mFA || fail_data !== mFD) begin
            errors++;
            $display("FAIL random[%0d] capture: got %0d/%0d, want %0d/%0d", it, fail_addr, fail_data, mFA, mFD);
         end
`endif
      end
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; cfg_we = 1'b0; cfg_idx = '0; cfg_addr = '0; cfg_data = '0;
      cfg_count = '0; start = 1'b0; MemWrite = 1'b0; DataAdr = '0; WriteData = '0;
      for (int i = 0; i < DEPTH; i++) begin tA[i] = 0; tD[i] = 0; end
      tick(); tick();
      test_reset();
      test_scratch_pass();
      test_wrong_addr();
      test_wrong_data();
      test_timeout();
      test_timeout_edge_store();
      test_multi_and_rerun();
      test_reset_midrun();
      test_cfg_ignored();
      test_count_zero();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
